// File: rtl/cordic_vectoring_iterative.sv
// -----------------------------------------------------------------------------
// cordic_vectoring_iterative
//
// Iterative CORDIC in vectoring mode. Takes a Cartesian vector (x_i, y_i) and
// drives y toward zero over 6 iterations of one shared add/shift slice. The
// magnitude comes out of x and the angle is accumulated in z as a binary angle.
//
// Build option:
//   CORDIC_VEC_GAIN_COMP_EN  When defined, a SCALE state removes the CORDIC
//                            gain, so mag_o is the true magnitude. Latency is
//                            8 cycles instead of 7. When undefined, mag_o
//                            carries the gain of about 1.646.
//
// Ports:
//   clk_i                    clock, rising edge
//   rst_i                    synchronous, active-high reset
//   x_i, y_i                 signed input vector, N_FRAC+1 bits
//   data_in_valid_strobe_i   one-cycle input strobe, ignored while busy_o=1
//   mag_o                    unsigned magnitude, N_FRAC+3 bits
//   angle_o                  signed binary angle, 1 LSB = pi/2^N_FRAC
//   data_out_valid_strobe_o  one-cycle result strobe
//   busy_o                   high whenever a calculation is in flight
// -----------------------------------------------------------------------------
module cordic_vectoring_iterative #(
  parameter int N_FRAC = 7
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic signed [N_FRAC:0]   x_i,
  input  logic signed [N_FRAC:0]   y_i,
  input  logic                     data_in_valid_strobe_i,
  output logic        [N_FRAC+2:0] mag_o,
  output logic signed [N_FRAC:0]   angle_o,
  output logic                     data_out_valid_strobe_o,
  output logic                     busy_o
);

  localparam int W  = N_FRAC + 1;  // input and angle width
  localparam int XW = N_FRAC + 3;  // x/y width: headroom for negation and gain

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] SCALE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Counter value once all 6 iterations have been applied.
  localparam logic [2:0] ITER_END = 3'd6;

  // -2^N_FRAC, i.e. +/-pi in binary-angle units.
  localparam logic signed [W-1:0] PI_ANGLE = {1'b1, {N_FRAC{1'b0}}};

  // atan(2^-i) in units of pi/2^N_FRAC (table shared with the rotation core).
  function automatic logic signed [W-1:0] atan_lut(input logic [2:0] idx);
    case (idx)
      3'd0:    atan_lut = W'(32);
      3'd1:    atan_lut = W'(18);
      3'd2:    atan_lut = W'(9);
      3'd3:    atan_lut = W'(5);
      3'd4:    atan_lut = W'(2);
      3'd5:    atan_lut = W'(1);
      default: atan_lut = '0;
    endcase
  endfunction

  logic [1:0]              state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic signed [XW-1:0]    x_q, x_d;
  logic signed [XW-1:0]    y_q, y_d;
  logic signed [W-1:0]     z_q, z_d;
  logic [XW-1:0]           mag_q, mag_d;
  logic signed [W-1:0]     angle_q, angle_d;

  logic signed [XW-1:0]    x_ext, y_ext;
  logic signed [XW-1:0]    x_sh, y_sh;

`ifdef CORDIC_VEC_GAIN_COMP_EN
  // 0.5 + 0.125 - 0.015625 - 0.001953 = 0.6074, close to 1/1.6465.
  logic signed [XW-1:0]    x_scaled;
  assign x_scaled = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9);
`endif

  assign x_ext = XW'(x_i);  // sign-extends: x_i is signed
  assign y_ext = XW'(y_i);
  assign x_sh  = x_q >>> cnt_q;
  assign y_sh  = y_q >>> cnt_q;

  always_comb begin
    // NOTE: every variable gets a hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mag_d   = mag_q;
    angle_d = angle_q;

    case (state_q)
      IDLE: begin
        if (data_in_valid_strobe_i) begin
          state_d = CALC;
          cnt_d   = '0;
          // Pre-rotate the left half-plane by pi so the iterations only ever
          // have to cover +/-pi/2.
          if (!x_i[N_FRAC]) begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end else begin
            x_d = -x_ext;
            y_d = -y_ext;
            z_d = PI_ANGLE;
          end
        end
      end

      CALC: begin
        if (cnt_q == ITER_END) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
          state_d = SCALE;
`else
          state_d = DONE;
          mag_d   = x_q;
          angle_d = z_q;
`endif
        end else begin
          // Rotate toward y = 0; both updates read the pre-update x and y.
          if (!y_q[XW-1]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_lut(cnt_q);
          end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_lut(cnt_q);
          end
          cnt_d = cnt_q + 3'd1;
        end
      end

`ifdef CORDIC_VEC_GAIN_COMP_EN
      SCALE: begin
        x_d     = x_scaled;
        state_d = DONE;
        mag_d   = x_scaled;
        angle_d = z_q;
      end
`endif

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: the datapath registers are reset along with the control state so
    // an aborted calculation leaves nothing visible on the outputs.
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mag_q   <= '0;
      angle_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      mag_q   <= mag_d;
      angle_q <= angle_d;
    end
  end

  assign mag_o                   = mag_q;
  assign angle_o                 = angle_q;
  assign data_out_valid_strobe_o = (state_q == DONE);
  assign busy_o                  = (state_q != IDLE);

endmodule

// File: tb/tb_cordic_vectoring_iterative.sv
module tb_cordic_vectoring_iterative;

  localparam int N_FRAC = 7;
`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam int EXP_LAT = 8;
  localparam bit COMP    = 1'b1;
`else
  localparam int EXP_LAT = 7;
  localparam bit COMP    = 1'b0;
`endif

  logic                     clk_i = 1'b0;
  logic                     rst_i = 1'b0;
  logic signed [N_FRAC:0]   x_i = '0;
  logic signed [N_FRAC:0]   y_i = '0;
  logic                     data_in_valid_strobe_i = 1'b0;
  logic        [N_FRAC+2:0] mag_o;
  logic signed [N_FRAC:0]   angle_o;
  logic                     data_out_valid_strobe_o;
  logic                     busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  cordic_vectoring_iterative #(.N_FRAC(N_FRAC)) dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .x_i                     (x_i),
    .y_i                     (y_i),
    .data_in_valid_strobe_i  (data_in_valid_strobe_i),
    .mag_o                   (mag_o),
    .angle_o                 (angle_o),
    .data_out_valid_strobe_o (data_out_valid_strobe_o),
    .busy_o                  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Wrap an angle difference into -128..127 (modulo 2pi).
  function automatic int wrap256(input int d);
    int r;
    r = d & 255;
    if (r > 127) r -= 256;
    return r;
  endfunction

  // Reference: the vectoring algorithm on plain integers.
  function automatic void model(input int xi, input int yi, output int mag, output int ang);
    int tab[6] = '{32, 18, 9, 5, 2, 1};
    int x, y, z, xn;
    if (xi >= 0) begin x = xi;  y = yi;  z = 0;    end
    else         begin x = -xi; y = -yi; z = -128; end
    for (int i = 0; i < 6; i++) begin
      if (y >= 0) begin xn = x + (y >>> i); y = y - (x >>> i); z += tab[i]; end
      else        begin xn = x - (y >>> i); y = y + (x >>> i); z -= tab[i]; end
      x = xn;
    end
    if (COMP) x = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
    mag = x & 1023;
    ang = wrap256(z);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Strobe one vector and wait (bounded) for the result strobe.
  task automatic run_one(input int xi, input int yi, output int lat, output int mag, output int ang);
    x_i = 8'(xi);
    y_i = 8'(yi);
    data_in_valid_strobe_i = 1'b1;
    step();
    data_in_valid_strobe_i = 1'b0;
    lat = 0;
    while (data_out_valid_strobe_o !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    mag = int'(mag_o);
    ang = int'(angle_o);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    n_checks++; if (mag_o !== '0) $display("FAIL reset_mag: got %0d want 0", mag_o); else n_pass++;
    n_checks++; if (angle_o !== '0) $display("FAIL reset_angle: got %0d want 0", angle_o); else n_pass++;
    n_checks++; if (data_out_valid_strobe_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", data_out_valid_strobe_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_directed();
    // x, y, ideal angle, magnitude without/with compensation, mag tolerance.
    // (-128,-128) lies at -3pi/4, i.e. -96 LSB.
    int tv[5][6] = '{
      '{  64,    0,    0, 105,  64, 2},
      '{   0,   64,   64, 105,  64, 2},
      '{  45,  -45,  -32, 105,  64, 2},
      '{ -64,    0, -128, 105,  64, 2},
      '{-128, -128,  -96, 298, 181, 3}
    };
    int lat, mag, ang, emag, eang, want_mag, d;
    for (int k = 0; k < 5; k++) begin
      run_one(tv[k][0], tv[k][1], lat, mag, ang);
      model(tv[k][0], tv[k][1], emag, eang);
      want_mag = COMP ? tv[k][4] : tv[k][3];
      n_checks++; if (lat !== EXP_LAT) $display("FAIL dir%0d_latency: got %0d want %0d", k, lat, EXP_LAT); else n_pass++;
      d = wrap256(ang - tv[k][2]);
      n_checks++; if (d > 2 || d < -2) $display("FAIL dir%0d_angle_tol: got %0d want %0d+-2", k, ang, tv[k][2]); else n_pass++;
      d = mag - want_mag;
      n_checks++; if (d > tv[k][5] || d < -tv[k][5]) $display("FAIL dir%0d_mag_tol: got %0d want %0d+-%0d", k, mag, want_mag, tv[k][5]); else n_pass++;
      n_checks++; if (ang !== eang) $display("FAIL dir%0d_angle: got %0d want %0d", k, ang, eang); else n_pass++;
      n_checks++; if (mag !== emag) $display("FAIL dir%0d_mag: got %0d want %0d", k, mag, emag); else n_pass++;
      step();
      n_checks++; if (data_out_valid_strobe_o !== 1'b0) $display("FAIL dir%0d_single_pulse: got %b want 0", k, data_out_valid_strobe_o); else n_pass++;
      n_checks++; if (busy_o !== 1'b0) $display("FAIL dir%0d_idle: got %b want 0", k, busy_o); else n_pass++;
    end
  endtask

  task automatic test_random();
    int xi, yi, lat, mag, ang, emag, eang;
    for (int k = 0; k < 30; k++) begin
      xi = int'($urandom_range(0, 255)) - 128;
      yi = int'($urandom_range(0, 255)) - 128;
      run_one(xi, yi, lat, mag, ang);
      model(xi, yi, emag, eang);
      n_checks++; if (lat !== EXP_LAT) $display("FAIL rnd_latency (%0d,%0d): got %0d want %0d", xi, yi, lat, EXP_LAT); else n_pass++;
      n_checks++; if (mag !== emag) $display("FAIL rnd_mag (%0d,%0d): got %0d want %0d", xi, yi, mag, emag); else n_pass++;
      n_checks++; if (ang !== eang) $display("FAIL rnd_angle (%0d,%0d): got %0d want %0d", xi, yi, ang, eang); else n_pass++;
      step();
    end
  endtask

  task automatic test_busy_ignore();
    int pulses, mag, ang, emag, eang;
    model(64, 0, emag, eang);
    x_i = 8'sd64;
    y_i = 8'sd0;
    data_in_valid_strobe_i = 1'b1;
    step();                       // E0: accepted
    data_in_valid_strobe_i = 1'b0;
    step();
    step();
    x_i = 8'sd0;
    y_i = 8'sd64;
    data_in_valid_strobe_i = 1'b1;
    step();                       // E3: busy, must be dropped
    data_in_valid_strobe_i = 1'b0;
    pulses = 0;
    mag = -1;
    ang = -1;
    for (int c = 0; c < 20; c++) begin
      if (data_out_valid_strobe_o === 1'b1) begin
        pulses++;
        mag = int'(mag_o);
        ang = int'(angle_o);
      end
      step();
    end
    n_checks++; if (pulses !== 1) $display("FAIL busy_pulses: got %0d want 1", pulses); else n_pass++;
    n_checks++; if (mag !== emag) $display("FAIL busy_mag: got %0d want %0d", mag, emag); else n_pass++;
    n_checks++; if (ang !== eang) $display("FAIL busy_angle: got %0d want %0d", ang, eang); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL busy_idle: got %b want 0", busy_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, mag, ang, emag, eang;
    run_one(-100, 37, lat, mag, ang);
    model(-100, 37, emag, eang);
    n_checks++; if (mag !== emag) $display("FAIL b2b_first_mag: got %0d want %0d", mag, emag); else n_pass++;
    // A strobe during the valid cycle is dropped; the next cycle's is taken.
    x_i = 8'sd90;
    y_i = -8'sd70;
    data_in_valid_strobe_i = 1'b1;
    step();
    n_checks++; if (busy_o !== 1'b0) $display("FAIL b2b_strobe_in_done: got busy %b want 0", busy_o); else n_pass++;
    step();
    data_in_valid_strobe_i = 1'b0;
    n_checks++; if (busy_o !== 1'b1) $display("FAIL b2b_accept: got busy %b want 1", busy_o); else n_pass++;
    lat = 0;
    while (data_out_valid_strobe_o !== 1'b1 && lat < 20) begin
      step();
      lat++;
    end
    model(90, -70, emag, eang);
    n_checks++; if (lat !== EXP_LAT) $display("FAIL b2b_latency: got %0d want %0d", lat, EXP_LAT); else n_pass++;
    n_checks++; if (int'(mag_o) !== emag) $display("FAIL b2b_mag: got %0d want %0d", mag_o, emag); else n_pass++;
    n_checks++; if (int'(angle_o) !== eang) $display("FAIL b2b_angle: got %0d want %0d", angle_o, eang); else n_pass++;
    step();
  endtask

  task automatic test_reset_mid();
    int pulses, lat, mag, ang, emag, eang;
    x_i = 8'sd45;
    y_i = -8'sd45;
    data_in_valid_strobe_i = 1'b1;
    step();                       // E0
    data_in_valid_strobe_i = 1'b0;
    step();
    step();
    step();
    rst_i = 1'b1;
    step();                       // E4: abort
    rst_i = 1'b0;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (data_out_valid_strobe_o === 1'b1) pulses++;
      step();
    end
    n_checks++; if (pulses !== 0) $display("FAIL abort_pulses: got %0d want 0", pulses); else n_pass++;
    n_checks++; if (mag_o !== '0) $display("FAIL abort_mag: got %0d want 0", mag_o); else n_pass++;
    n_checks++; if (angle_o !== '0) $display("FAIL abort_angle: got %0d want 0", angle_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy_o); else n_pass++;

    // Reset and strobe together: reset wins.
    x_i = 8'sd64;
    y_i = 8'sd0;
    rst_i = 1'b1;
    data_in_valid_strobe_i = 1'b1;
    step();
    rst_i = 1'b0;
    data_in_valid_strobe_i = 1'b0;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_strobe_busy: got %b want 0", busy_o); else n_pass++;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (data_out_valid_strobe_o === 1'b1) pulses++;
      step();
    end
    n_checks++; if (pulses !== 0) $display("FAIL rst_strobe_pulses: got %0d want 0", pulses); else n_pass++;

    // Recovery after reset.
    run_one(0, -64, lat, mag, ang);
    model(0, -64, emag, eang);
    n_checks++; if (lat !== EXP_LAT) $display("FAIL recover_latency: got %0d want %0d", lat, EXP_LAT); else n_pass++;
    n_checks++; if (ang !== eang) $display("FAIL recover_angle: got %0d want %0d", ang, eang); else n_pass++;
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
